alu_issue_queue: RTL and testbench

- In-order dispatch, out-of-order issue reservation station in front of the single-cycle integer ALU.
- Buffers up to DEPTH renamed ALU/branch/jump micro-ops and captures source operands from the common data bus (CDB).
- Each cycle, selects the oldest entry with both operands ready and drives the ALU input bundle from a registered issue stage.
- Sits between rename/dispatch and the ALU; a mispredict flush empties it.

---
 rtl/alu_issue_queue_if.sv | 57 +++++
 rtl/alu_issue_queue.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB and issue bundle for alu_issue_queue.
// master drives dispatch/CDB/flush (rename side); slave is the queue itself.
interface alu_issue_queue_if #(
    parameter int PREG_W = 7,
    parameter int ROB_W  = 3
);
    logic              dis_valid;
    logic              dis_ready;
    logic [4:0]        dis_opcode;
    logic [2:0]        dis_funct3;
    logic              dis_funct7;
    logic [PREG_W-1:0] dis_rs1_tag;
    logic [PREG_W-1:0] dis_rs2_tag;
    logic              dis_rs1_rdy;
    logic              dis_rs2_rdy;
    logic [31:0]       dis_rs1_data;
    logic [31:0]       dis_rs2_data;
    logic [31:0]       dis_imm;
    logic [31:0]       dis_pc;
    logic [ROB_W-1:0]  dis_rob_idx;
    logic [PREG_W-1:0] dis_rd;

    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_tag;
    logic [31:0]       cdb_data;

    logic              flush;

    logic              iss_valid;
    logic [4:0]        iss_opcode;
    logic [2:0]        iss_funct3;
    logic              iss_funct7;
    logic [31:0]       iss_rs1_data;
    logic [31:0]       iss_rs2_data;
    logic [31:0]       iss_imm;
    logic [31:0]       iss_pc;
    logic [ROB_W-1:0]  iss_rob_idx;
    logic [PREG_W-1:0] iss_rd;

    modport master (
        output dis_valid, dis_opcode, dis_funct3, dis_funct7,
               dis_rs1_tag, dis_rs2_tag, dis_rs1_rdy, dis_rs2_rdy,
               dis_rs1_data, dis_rs2_data, dis_imm, dis_pc, dis_rob_idx, dis_rd,
               cdb_valid, cdb_tag, cdb_data, flush,
        input  dis_ready, iss_valid, iss_opcode, iss_funct3, iss_funct7,
               iss_rs1_data, iss_rs2_data, iss_imm, iss_pc, iss_rob_idx, iss_rd
    );

    modport slave (
        input  dis_valid, dis_opcode, dis_funct3, dis_funct7,
               dis_rs1_tag, dis_rs2_tag, dis_rs1_rdy, dis_rs2_rdy,
               dis_rs1_data, dis_rs2_data, dis_imm, dis_pc, dis_rob_idx, dis_rd,
               cdb_valid, cdb_tag, cdb_data, flush,
        output dis_ready, iss_valid, iss_opcode, iss_funct3, iss_funct7,
               iss_rs1_data, iss_rs2_data, iss_imm, iss_pc, iss_rob_idx, iss_rd
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing out-of-order issue queue feeding the single-cycle ALU through a registered issue stage.
// Optional macro ALU_IQ_WAKEUP_BYPASS_EN lets a same-cycle CDB broadcast make an entry selectable.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 3
) (
    input logic         clk,
    input logic         rst_n,
    alu_issue_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [4:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7;
        logic              rs1_rdy;
        logic [PREG_W-1:0] rs1_tag;
        logic [31:0]       rs1_data;
        logic              rs2_rdy;
        logic [PREG_W-1:0] rs2_tag;
        logic [31:0]       rs2_data;
        logic [31:0]       imm;
        logic [31:0]       pc;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] rd;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7;
        logic [31:0]       rs1_data;
        logic [31:0]       rs2_data;
        logic [31:0]       imm;
        logic [31:0]       pc;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] rd;
    } iss_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    entry_t           woken     [DEPTH+1];
    entry_t           incoming;
    iss_t             iss_q, iss_d;
    logic [CNT_W-1:0] count_q, count_d, count_kept;
    logic             dis_ready, dis_fire, sel_found, rdy_ok;
    int               sel_idx;

    // Tag 0 is the hardwired zero register and never wakes a waiting source.
    function automatic entry_t wake(input entry_t e, input logic cv,
                                    input logic [PREG_W-1:0] tag, input logic [31:0] data);
        entry_t r;
        r = e;
        if (cv && tag != '0) begin
            if (!r.rs1_rdy && r.rs1_tag == tag) begin
                r.rs1_rdy  = 1'b1;
                r.rs1_data = data;
            end
            if (!r.rs2_rdy && r.rs2_tag == tag) begin
                r.rs2_rdy  = 1'b1;
                r.rs2_data = data;
            end
        end
        return r;
    endfunction

    assign dis_ready     = (count_q != CNT_W'(DEPTH));
    assign dis_fire      = bus.dis_valid && dis_ready;
    assign bus.dis_ready = dis_ready;

    always_comb begin
        incoming          = '0;
        incoming.valid    = 1'b1;
        incoming.opcode   = bus.dis_opcode;
        incoming.funct3   = bus.dis_funct3;
        incoming.funct7   = bus.dis_funct7;
        incoming.rs1_rdy  = bus.dis_rs1_rdy;
        incoming.rs1_tag  = bus.dis_rs1_tag;
        incoming.rs1_data = bus.dis_rs1_data;
        incoming.rs2_rdy  = bus.dis_rs2_rdy;
        incoming.rs2_tag  = bus.dis_rs2_tag;
        incoming.rs2_data = bus.dis_rs2_data;
        incoming.imm      = bus.dis_imm;
        incoming.pc       = bus.dis_pc;
        incoming.rob_idx  = bus.dis_rob_idx;
        incoming.rd       = bus.dis_rd;
        incoming          = wake(incoming, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake(entries_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        woken[DEPTH] = '0;

        // Oldest-first select; operand data comes from the woken view so a bypassed value is captured.
        sel_found = 1'b0;
        sel_idx   = 0;
        rdy_ok    = 1'b0;
        iss_d     = iss_q;
        iss_d.valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
            rdy_ok = woken[i].rs1_rdy && woken[i].rs2_rdy;
`else
            rdy_ok = entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
`endif
            if (!sel_found && entries_q[i].valid && rdy_ok) begin
                sel_found          = 1'b1;
                sel_idx            = i;
                iss_d.valid        = 1'b1;
                iss_d.opcode       = woken[i].opcode;
                iss_d.funct3       = woken[i].funct3;
                iss_d.funct7       = woken[i].funct7;
                iss_d.rs1_data     = woken[i].rs1_data;
                iss_d.rs2_data     = woken[i].rs2_data;
                iss_d.imm          = woken[i].imm;
                iss_d.pc           = woken[i].pc;
                iss_d.rob_idx      = woken[i].rob_idx;
                iss_d.rd           = woken[i].rd;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = (sel_found && i >= sel_idx) ? woken[i+1] : woken[i];
        end
        count_kept = count_q - {{(CNT_W-1){1'b0}}, sel_found};
        count_d    = count_kept;

        if (dis_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(count_kept)) begin
                    entries_d[i] = incoming;
                end
            end
            count_d = count_kept + CNT_W'(1);
        end

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d     = '0;
            iss_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            iss_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            iss_q     <= iss_d;
        end
    end

    assign bus.iss_valid    = iss_q.valid;
    assign bus.iss_opcode   = iss_q.opcode;
    assign bus.iss_funct3   = iss_q.funct3;
    assign bus.iss_funct7   = iss_q.funct7;
    assign bus.iss_rs1_data = iss_q.rs1_data;
    assign bus.iss_rs2_data = iss_q.rs2_data;
    assign bus.iss_imm      = iss_q.imm;
    assign bus.iss_pc       = iss_q.pc;
    assign bus.iss_rob_idx  = iss_q.rob_idx;
    assign bus.iss_rd       = iss_q.rd;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed dispatch/CDB/flush/reset vectors,
// expected issues queued by the stimulus and checked by an independent monitor.
module tb_alu_issue_queue;
    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [6:0]  rs1_tag;
        logic        rs1_rdy;
        logic [31:0] rs1_data;
        logic [6:0]  rs2_tag;
        logic        rs2_rdy;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  rob_idx;
        logic [6:0]  rd;
    } dop_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  rob_idx;
        logic [6:0]  rd;
    } iss_t;

    typedef struct {
        iss_t fields;
        int   cyc;
    } exp_t;

`ifdef ALU_IQ_WAKEUP_BYPASS_EN
    localparam int WAKE_LAT = 1;
`else
    localparam int WAKE_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb [$];
    dop_t nop = '0;

    alu_issue_queue_if #(.PREG_W(7), .ROB_W(3)) bus ();

    alu_issue_queue #(.DEPTH(4), .PREG_W(7), .ROB_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic dop_t mkOp(input logic [4:0] opc, input logic [2:0] f3, input logic f7,
                                  input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                                  input logic [6:0] t2, input logic r2, input logic [31:0] d2,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  input logic [2:0] rob, input logic [6:0] rd);
        return '{opc, f3, f7, t1, r1, d1, t2, r2, d2, imm, pc, rob, rd};
    endfunction

    function automatic iss_t expOf(input dop_t op, input logic [31:0] a, input logic [31:0] b);
        return '{op.opcode, op.funct3, op.funct7, a, b, op.imm, op.pc, op.rob_idx, op.rd};
    endfunction

    task automatic expectIssue(input dop_t op, input logic [31:0] a, input logic [31:0] b, input int at);
        exp_t e;
        e.fields = expOf(op, a, b);
        e.cyc    = at;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input dop_t op, input logic dv, input logic cv,
                                 input logic [6:0] ctag, input logic [31:0] cdata, input logic fl);
        bus.dis_valid    = dv;
        bus.dis_opcode   = op.opcode;
        bus.dis_funct3   = op.funct3;
        bus.dis_funct7   = op.funct7;
        bus.dis_rs1_tag  = op.rs1_tag;
        bus.dis_rs1_rdy  = op.rs1_rdy;
        bus.dis_rs1_data = op.rs1_data;
        bus.dis_rs2_tag  = op.rs2_tag;
        bus.dis_rs2_rdy  = op.rs2_rdy;
        bus.dis_rs2_data = op.rs2_data;
        bus.dis_imm      = op.imm;
        bus.dis_pc       = op.pc;
        bus.dis_rob_idx  = op.rob_idx;
        bus.dis_rd       = op.rd;
        bus.cdb_valid    = cv;
        bus.cdb_tag      = ctag;
        bus.cdb_data     = cdata;
        bus.flush        = fl;
        @(posedge clk);
        #1;
        bus.dis_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(nop, 1'b0, 1'b0, 7'h0, 32'h0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every issued micro-op must match the oldest outstanding expectation, in content and cycle.
    always @(negedge clk) begin
        if (bus.iss_valid === 1'b1) begin
            iss_t got;
            exp_t e;
            got = '{bus.iss_opcode, bus.iss_funct3, bus.iss_funct7, bus.iss_rs1_data, bus.iss_rs2_data,
                    bus.iss_imm, bus.iss_pc, bus.iss_rob_idx, bus.iss_rd};
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_issue: got rob %0d rd %h, want no issue (cycle %0d)",
                         bus.iss_rob_idx, bus.iss_rd, cyc);
            end else begin
                e = sb.pop_front();
                if (got !== e.fields) begin
                    mismatched++;
                    $display("[TB] FAIL issue_fields: got %h, want %h (cycle %0d)", got, e.fields, cyc);
                end
                compared++;
                if (cyc != e.cyc) begin
                    mismatched++;
                    $display("[TB] FAIL issue_cycle: got %0d, want %0d (rob %0d)", cyc, e.cyc, bus.iss_rob_idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dop_t opA, opB, opF, opG, opH, opD, opE, opX;
        dop_t fill [4];

        bus.dis_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.flush     = 1'b0;
        applyStimulus(nop, 1'b0, 1'b0, 7'h0, 32'h0, 1'b0);
        applyStimulus(nop, 1'b0, 1'b0, 7'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        checkOutput("reset_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
        checkOutput("reset_dis_ready", {31'b0, bus.dis_ready}, 32'd1);
        checkOutput("reset_iss_rd", {25'b0, bus.iss_rd}, 32'd0);

        // Simple ADD, both operands ready.
        opA = mkOp(5'b01100, 3'b000, 1'b0, 7'h01, 1'b1, 32'd5, 7'h02, 1'b1, 32'd7,
                   32'h0, 32'h100, 3'd2, 7'h11);
        expectIssue(opA, 32'd5, 32'd7, cyc + 2);
        applyStimulus(opA, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        checkOutput("add_dis_ready", {31'b0, bus.dis_ready}, 32'd1);
        idle(3);

        // A waits on tag 0x20, B is ready and overtakes it.
        opA = mkOp(5'b01100, 3'b100, 1'b0, 7'h20, 1'b0, 32'h0, 7'h03, 1'b1, 32'd3,
                   32'h0, 32'h104, 3'd3, 7'h12);
        opB = mkOp(5'b01100, 3'b110, 1'b1, 7'h04, 1'b1, 32'h10, 7'h05, 1'b1, 32'h20,
                   32'h0, 32'h108, 3'd4, 7'h13);
        applyStimulus(opA, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        expectIssue(opB, 32'h10, 32'h20, cyc + 2);
        applyStimulus(opB, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        idle(1);
        expectIssue(opA, 32'h1234, 32'd3, cyc + WAKE_LAT);
        applyStimulus(nop, 1'b0, 1'b1, 7'h20, 32'h1234, 1'b0);
        idle(3);

        // Fill the queue with four waiting entries.
        for (int i = 0; i < 4; i++) begin
            fill[i] = mkOp(5'b00100, 3'(i), 1'b0, 7'(8'h41 + i), 1'b0, 32'h0, 7'h00, 1'b1, 32'(i + 100),
                           32'(i), 32'(32'h200 + 4 * i), 3'(i), 7'(8'h60 + i));
            applyStimulus(fill[i], 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        end
        checkOutput("full_dis_ready", {31'b0, bus.dis_ready}, 32'd0);
        opX = mkOp(5'b01100, 3'b000, 1'b0, 7'h00, 1'b1, 32'h77, 7'h00, 1'b1, 32'h88,
                   32'h0, 32'h300, 3'd7, 7'h17);
        applyStimulus(opX, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        checkOutput("full_dis_ready_hold", {31'b0, bus.dis_ready}, 32'd0);
        expectIssue(fill[1], 32'hAA, 32'd101, cyc + WAKE_LAT);
        applyStimulus(nop, 1'b0, 1'b1, 7'h42, 32'hAA, 1'b0);
        idle(1);
        checkOutput("release_dis_ready", {31'b0, bus.dis_ready}, 32'd1);

        // Three waiting entries plus D in the issue register, then flush with a dropped dispatch.
        opD = mkOp(5'b11000, 3'b001, 1'b0, 7'h06, 1'b1, 32'h99, 7'h07, 1'b1, 32'h98,
                   32'hFFFF_FFF0, 32'h400, 3'd5, 7'h15);
        opE = mkOp(5'b01100, 3'b000, 1'b0, 7'h00, 1'b1, 32'h1, 7'h00, 1'b1, 32'h2,
                   32'h0, 32'h404, 3'd6, 7'h18);
        expectIssue(opD, 32'h99, 32'h98, cyc + 2);
        applyStimulus(opD, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        idle(1);
        checkOutput("preflush_iss_valid", {31'b0, bus.iss_valid}, 32'd1);
        applyStimulus(opE, 1'b1, 1'b0, 7'h0, 32'h0, 1'b1);
        checkOutput("flush_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
        checkOutput("flush_dis_ready", {31'b0, bus.dis_ready}, 32'd1);
        applyStimulus(nop, 1'b0, 1'b1, 7'h41, 32'h5, 1'b0);
        applyStimulus(nop, 1'b0, 1'b1, 7'h43, 32'h6, 1'b0);
        applyStimulus(nop, 1'b0, 1'b1, 7'h44, 32'h7, 1'b0);
        idle(3);

        // Same-cycle CDB capture at dispatch, then tag 0 that must not wake.
        opF = mkOp(5'b00100, 3'b111, 1'b0, 7'h08, 1'b1, 32'h0F0F, 7'h30, 1'b0, 32'h0,
                   32'h7FF, 32'h500, 3'd6, 7'h16);
        expectIssue(opF, 32'h0F0F, 32'h5555, cyc + 2);
        applyStimulus(opF, 1'b1, 1'b1, 7'h30, 32'h5555, 1'b0);
        idle(3);
        opG = mkOp(5'b01100, 3'b000, 1'b0, 7'h00, 1'b0, 32'h0, 7'h09, 1'b1, 32'h3,
                   32'h0, 32'h504, 3'd1, 7'h19);
        opH = mkOp(5'b01100, 3'b010, 1'b0, 7'h50, 1'b0, 32'h0, 7'h0A, 1'b1, 32'h4,
                   32'h0, 32'h508, 3'd0, 7'h1A);
        applyStimulus(opG, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        applyStimulus(nop, 1'b0, 1'b1, 7'h00, 32'hDEAD, 1'b0);
        applyStimulus(opH, 1'b1, 1'b0, 7'h0, 32'h0, 1'b0);
        idle(3);
        checkOutput("pending_iss_rs1", bus.iss_rs1_data, 32'h0F0F);

        // Reset for one edge with G and H pending.
        rst_n = 1'b0;
        applyStimulus(nop, 1'b0, 1'b0, 7'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        checkOutput("rst_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
        checkOutput("rst_dis_ready", {31'b0, bus.dis_ready}, 32'd1);
        checkOutput("rst_iss_rs1", bus.iss_rs1_data, 32'h0);
        checkOutput("rst_iss_rs2", bus.iss_rs2_data, 32'h0);
        checkOutput("rst_iss_imm", bus.iss_imm, 32'h0);
        checkOutput("rst_iss_pc", bus.iss_pc, 32'h0);
        checkOutput("rst_iss_ctl", {20'b0, bus.iss_opcode, bus.iss_funct3, bus.iss_funct7, bus.iss_rob_idx},
                    32'h0);
        checkOutput("rst_iss_rd", {25'b0, bus.iss_rd}, 32'd0);
        applyStimulus(nop, 1'b0, 1'b1, 7'h50, 32'h9, 1'b0);
        idle(4);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
